blk2raster_ctrl: RTL and testbench

Reorders decoded 8x8 pixel blocks into raster-scan lines using the shared 8-bit generic RAM as a one-strip buffer. It sits after the IDCT/colour stage:
- It accepts one 8-pixel-high strip of blocks in block order and writes it into the RAM at raster addresses.
- It then reads the strip back in raster order to the display/output stage.
- It is the sole initiator on the RAM port, driving address, write data, write enable and read enable.

---
 rtl/blk2raster_pkg.sv | 12 +
 rtl/blk2raster_ctrl_if.sv | 41 ++++
 rtl/blk2raster_addr_gen.sv | 47 ++++
 rtl/blk2raster_ctrl.sv | 128 ++++++++++++
 tb/tb_blk2raster_ctrl.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/blk2raster_pkg.sv
// rtl/blk2raster_pkg.sv - shared types and widths for the block-to-raster reorder controller
package blk2raster_pkg;

   localparam int PIX_W  = 8;
   localparam int ADDR_W = 10;

   typedef enum logic {
      S_WRITE = 1'b0,
      S_READ  = 1'b1
   } state_t;

endpackage

// File: rtl/blk2raster_ctrl_if.sv
// rtl/blk2raster_ctrl_if.sv - pixel streams and RAM port bundle; BLK2RASTER_FRAME_CNT_EN adds frame_done
interface blk2raster_ctrl_if;
   import blk2raster_pkg::*;

   logic [PIX_W-1:0]  in_data;
   logic              in_valid;
   logic              in_ready;
   logic [PIX_W-1:0]  out_data;
   logic              out_valid;
   logic              out_ready;
   logic              strip_done;
   logic [ADDR_W-1:0] ram_addr;
   logic [PIX_W-1:0]  ram_din;
   logic              ram_wr_en;
   logic              ram_rd_en;
   logic [PIX_W-1:0]  ram_dout;
`ifdef BLK2RASTER_FRAME_CNT_EN
   logic              frame_done;
`endif

   // Controller side
   modport master (
      input  in_data, in_valid, out_ready, ram_dout,
      output in_ready, out_data, out_valid, strip_done,
      output ram_addr, ram_din, ram_wr_en, ram_rd_en
`ifdef BLK2RASTER_FRAME_CNT_EN
      , output frame_done
`endif
   );

   // Producer, consumer and RAM side
   modport slave (
      output in_data, in_valid, out_ready, ram_dout,
      input  in_ready, out_data, out_valid, strip_done,
      input  ram_addr, ram_din, ram_wr_en, ram_rd_en
`ifdef BLK2RASTER_FRAME_CNT_EN
      , input frame_done
`endif
   );

endinterface

// File: rtl/blk2raster_addr_gen.sv
// rtl/blk2raster_addr_gen.sv - block-order col/row/blk counters mapped to raster write addresses
module blk2raster_addr_gen
   import blk2raster_pkg::*;
#(
   parameter int IMG_W = 80
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              step,
   input  logic              clear,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   localparam int NB = IMG_W / 8;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [BW-1:0] BLK_LAST = BW'(NB - 1);

   logic [2:0]    col;
   logic [2:0]    row;
   logic [BW-1:0] blk;

   // Walk col fastest, then row, then block; clear wins over step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
         blk <= '0;
      end else if (clear) begin
         col <= '0;
         row <= '0;
         blk <= '0;
      end else if (step) begin
         col <= col + 3'd1;
         if (col == 3'd7) begin
            row <= row + 3'd1;
            if (row == 3'd7) begin
               blk <= blk + BW'(1);
            end
         end
      end
   end

   assign last = (blk == BLK_LAST) && (row == 3'd7) && (col == 3'd7);
   assign addr = ADDR_W'(row) * ADDR_W'(IMG_W) + (ADDR_W'(blk) << 3) + ADDR_W'(col);

endmodule

// File: rtl/blk2raster_ctrl.sv
// rtl/blk2raster_ctrl.sv - fills a one-strip RAM buffer in block order, drains it in raster order; BLK2RASTER_FRAME_CNT_EN adds frame counting
module blk2raster_ctrl
   import blk2raster_pkg::*;
#(
   parameter int IMG_W      = 80,
   parameter int NUM_STRIPS = 60
) (
   input  logic            clk,
   input  logic            rst_n,
   blk2raster_ctrl_if.master bus
);

   localparam int STRIP_SZ = IMG_W * 8;
   localparam logic [ADDR_W-1:0] RD_LAST = ADDR_W'(STRIP_SZ - 1);

   // Reject geometries the RAM buffer cannot hold
   if ((IMG_W % 8 != 0) || (STRIP_SZ > 1024) || (NUM_STRIPS < 1)) begin : g_bad_cfg
      $error("blk2raster_ctrl: unsupported IMG_W/NUM_STRIPS");
   end

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W-1:0] wr_addr;
   logic              wr_last;
   logic              wr_xfer;
   logic              rd_xfer;
   logic              rd_last_hs;
   logic              strip_done_q;

   blk2raster_addr_gen #(.IMG_W(IMG_W)) u_addr_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .step  (wr_xfer),
      .clear (wr_xfer & wr_last),
      .addr  (wr_addr),
      .last  (wr_last)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_WRITE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and RAM/stream outputs; in_ready is gated by rst_n so nothing is accepted during reset
   always_comb begin
      state_nxt     = state;
      wr_xfer       = 1'b0;
      rd_xfer       = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_data  = '0;
      bus.ram_addr  = '0;
      bus.ram_din   = '0;
      bus.ram_wr_en = 1'b0;
      bus.ram_rd_en = 1'b0;
      case (state)
         S_WRITE: begin
            bus.in_ready = rst_n;
            wr_xfer      = bus.in_valid & rst_n;
            if (wr_xfer) begin
               bus.ram_wr_en = 1'b1;
               bus.ram_din   = bus.in_data;
               bus.ram_addr  = wr_addr;
               if (wr_last) begin
                  state_nxt = S_READ;
               end
            end
         end
         S_READ: begin
            bus.ram_rd_en = 1'b1;
            bus.ram_addr  = rd_ptr;
            bus.out_valid = 1'b1;
            bus.out_data  = bus.ram_dout;
            rd_xfer       = bus.out_ready;
            if (rd_xfer && (rd_ptr == RD_LAST)) begin
               state_nxt = S_WRITE;
            end
         end
         default: state_nxt = S_WRITE;
      endcase
   end

   assign rd_last_hs = rd_xfer && (rd_ptr == RD_LAST);

   // Raster read pointer advances only on handshakes; strip_done follows the final one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr       <= '0;
         strip_done_q <= 1'b0;
      end else begin
         strip_done_q <= rd_last_hs;
         if (rd_xfer) begin
            rd_ptr <= rd_last_hs ? '0 : rd_ptr + ADDR_W'(1);
         end
      end
   end

   assign bus.strip_done = strip_done_q;

`ifdef BLK2RASTER_FRAME_CNT_EN
   localparam int SC_W = (NUM_STRIPS > 1) ? $clog2(NUM_STRIPS) : 1;
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(NUM_STRIPS - 1);

   logic [SC_W-1:0] strip_cnt;
   logic            frame_done_q;

   // Count completed strips; frame_done coincides with the strip_done of the last strip
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         strip_cnt    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= rd_last_hs && (strip_cnt == SC_LAST);
         if (rd_last_hs) begin
            strip_cnt <= (strip_cnt == SC_LAST) ? '0 : strip_cnt + SC_W'(1);
         end
      end
   end

   assign bus.frame_done = frame_done_q;
`endif

endmodule

// File: tb/tb_blk2raster_ctrl.sv
// tb/tb_blk2raster_ctrl.sv - directed bench for blk2raster_ctrl with IMG_W=16 and an attached strip RAM
module tb_blk2raster_ctrl;
   import blk2raster_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   blk2raster_ctrl_if bus ();

   blk2raster_ctrl #(.IMG_W(16), .NUM_STRIPS(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [7:0] mem [0:127];

   always @(posedge clk) begin
      if (bus.ram_wr_en) mem[bus.ram_addr[6:0]] <= bus.ram_din;
   end

   assign bus.ram_dout = bus.ram_rd_en ? mem[bus.ram_addr[6:0]] : 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int wexp(input int k);
      return ((k / 8) % 8) * 16 + (k / 64) * 8 + (k % 8);
   endfunction

   function automatic int rexp(input int i, input int seed);
      int idx;
      idx = ((i % 16) / 8) * 64 + (i / 16) * 8 + (i % 8);
      return (idx + seed) & 255;
   endfunction

   task automatic write_pix(input int k_from, input int k_to, input int seed);
      for (int k = k_from; k <= k_to; k++) begin
         @(negedge clk);
         bus.in_valid  = 1'b1;
         bus.in_data   = 8'((k + seed) & 255);
         bus.out_ready = 1'b1;
         #1;
         chk("wr_in_ready", bus.in_ready, 1);
         chk("wr_en", bus.ram_wr_en, 1);
         chk("wr_addr", bus.ram_addr, wexp(k));
         chk("wr_din", bus.ram_din, (k + seed) & 255);
         chk("wr_out_valid", bus.out_valid, 0);
         chk("wr_rd_en", bus.ram_rd_en, 0);
      end
   endtask

   task automatic read_fast(input int seed, input logic exp_frame);
      for (int i = 0; i < 128; i++) begin
         @(negedge clk);
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b1;
         #1;
         chk("rd_out_valid", bus.out_valid, 1);
         chk("rd_out_data", bus.out_data, rexp(i, seed));
         chk("rd_addr", bus.ram_addr, i);
         chk("rd_en", bus.ram_rd_en, 1);
         chk("rd_in_ready", bus.in_ready, 0);
         chk("rd_strip_done", bus.strip_done, 0);
`ifdef BLK2RASTER_FRAME_CNT_EN
         chk("rd_frame_done", bus.frame_done, 0);
`endif
      end
      @(negedge clk);
      bus.out_ready = 1'b0;
      #1;
      chk("sd_strip_done", bus.strip_done, 1);
      chk("sd_in_ready", bus.in_ready, 1);
      chk("sd_out_valid", bus.out_valid, 0);
      chk("sd_out_data", bus.out_data, 0);
      chk("sd_rd_en", bus.ram_rd_en, 0);
`ifdef BLK2RASTER_FRAME_CNT_EN
      chk("sd_frame_done", bus.frame_done, exp_frame);
`endif
      @(negedge clk);
      #1;
      chk("sd_pulse_end", bus.strip_done, 0);
   endtask

   task automatic read_toggle(input int seed, input logic exp_frame);
      int p = 0;
      int c = 0;
      while (p < 128 && c < 400) begin
         @(negedge clk);
         bus.in_valid  = 1'b1;
         bus.in_data   = 8'h77;
         bus.out_ready = (c % 2 == 0);
         #1;
         chk("tg_out_valid", bus.out_valid, 1);
         chk("tg_out_data", bus.out_data, rexp(p, seed));
         chk("tg_addr", bus.ram_addr, p);
         chk("tg_in_ready", bus.in_ready, 0);
         chk("tg_wr_en", bus.ram_wr_en, 0);
         chk("tg_strip_done", bus.strip_done, 0);
         if (bus.out_ready) p++;
         c++;
      end
      chk("tg_cycles", c, 255);
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h77;
      bus.out_ready = 1'b0;
      #1;
      chk("tg_sd_strip_done", bus.strip_done, 1);
      chk("tg_sd_in_ready", bus.in_ready, 1);
      chk("tg_sd_wr_en", bus.ram_wr_en, 1);
      chk("tg_sd_addr", bus.ram_addr, 0);
      chk("tg_sd_din", bus.ram_din, 8'h77);
`ifdef BLK2RASTER_FRAME_CNT_EN
      chk("tg_sd_frame_done", bus.frame_done, exp_frame);
`endif
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, bus.in_ready, 0);
      chk({tag, "_out_valid"}, bus.out_valid, 0);
      chk({tag, "_out_data"}, bus.out_data, 0);
      chk({tag, "_strip_done"}, bus.strip_done, 0);
      chk({tag, "_wr_en"}, bus.ram_wr_en, 0);
      chk({tag, "_rd_en"}, bus.ram_rd_en, 0);
      chk({tag, "_addr"}, bus.ram_addr, 0);
      chk({tag, "_din"}, bus.ram_din, 0);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk_reset_outputs("rst");

      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("idle_in_ready", bus.in_ready, 1);
      chk("idle_out_valid", bus.out_valid, 0);
      chk("idle_wr_en", bus.ram_wr_en, 0);
      chk("idle_addr", bus.ram_addr, 0);
      @(negedge clk);
      #1;
      chk("idle2_in_ready", bus.in_ready, 1);
      chk("idle2_wr_en", bus.ram_wr_en, 0);

      // Strip 1: back-to-back fill and full-rate readout
      write_pix(0, 127, 0);
      read_fast(0, 1'b0);

      // Strip 2: stalled readout with in_valid held high, next strip starts on strip_done
      write_pix(0, 127, 8'h40);
      read_toggle(8'h40, 1'b1);

      // Partial strip of 70 pixels (pixel 0 was 0x77), then reset mid-strip
      write_pix(1, 69, 8'h20);
      @(negedge clk);
      rst_n        = 1'b0;
      bus.in_valid = 1'b1;
      #1;
      chk_reset_outputs("mid_rst");
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n        = 1'b1;
      #1;
      chk("post_rst_in_ready", bus.in_ready, 1);
      chk("post_rst_addr", bus.ram_addr, 0);

      // Fresh strip after reset reads back intact
      write_pix(0, 127, 8'h90);
      read_fast(8'h90, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
